// File: rtl/seq_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first, (rep+1) times,
// with busy/done handshake. Define SEQ_TX_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_tx #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] PATTERN = 5'b11011,
    parameter int               GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pat_sel,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [3:0]       rep,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef SEQ_TX_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] cap, cap_nx;
    logic [CW-1:0]    bitcnt, bitcnt_nx;
    logic [3:0]       repcnt, repcnt_nx;
    logic [WIDTH-1:0] sel_pat;
    logic             dout_nx, dout_valid_nx, busy_nx, done_nx;

`ifdef SEQ_TX_GAP_EN
    logic [3:0]       gapcnt, gapcnt_nx;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_LEN - 1);
`else
    logic             unused_gap_len;
    assign unused_gap_len = ^GAP_LEN;
`endif

    assign sel_pat = pat_sel ? pat_in : PATTERN;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nx  = state;
        shreg_nx  = shreg;
        cap_nx    = cap;
        bitcnt_nx = bitcnt;
        repcnt_nx = repcnt;
`ifdef SEQ_TX_GAP_EN
        gapcnt_nx = gapcnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    cap_nx    = sel_pat;
                    shreg_nx  = sel_pat;
                    repcnt_nx = rep;
                    bitcnt_nx = LAST_BIT;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                if (bitcnt == '0) begin
                    if (repcnt != 4'd0) begin
                        // Reload from the capture register so input changes mid-burst are invisible.
                        shreg_nx  = cap;
                        repcnt_nx = repcnt - 4'd1;
                        bitcnt_nx = LAST_BIT;
`ifdef SEQ_TX_GAP_EN
                        gapcnt_nx = GAP_LOAD;
                        state_nx  = GAP;
`endif
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    bitcnt_nx = bitcnt - CW'(1);
                end
            end
`ifdef SEQ_TX_GAP_EN
            GAP: begin
                if (gapcnt == 4'd0) state_nx = SHIFT;
                else                gapcnt_nx = gapcnt - 4'd1;
            end
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values and registered, so they line up with the state.
    always_comb begin
        dout_valid_nx = (state_nx == SHIFT);
        dout_nx       = dout_valid_nx & shreg_nx[WIDTH-1];
        done_nx       = (state_nx == DONE);
`ifdef SEQ_TX_GAP_EN
        busy_nx       = (state_nx == SHIFT) || (state_nx == GAP);
`else
        busy_nx       = (state_nx == SHIFT);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cap        <= '0;
            bitcnt     <= '0;
            repcnt     <= '0;
`ifdef SEQ_TX_GAP_EN
            gapcnt     <= '0;
`endif
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cap        <= cap_nx;
            bitcnt     <= bitcnt_nx;
            repcnt     <= repcnt_nx;
`ifdef SEQ_TX_GAP_EN
            gapcnt     <= gapcnt_nx;
`endif
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: each accepted start queues one expected record per cycle
// ({dout_valid, dout, busy, done}); every cycle pops one record and compares it with the DUT.
module tb_seq_tx;

    localparam int             W   = 5;
    localparam logic [W-1:0]   PAT = 5'b11011;
    localparam int             GAP = 2;
`ifdef SEQ_TX_GAP_EN
    localparam int             G   = GAP;
`else
    localparam int             G   = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         pat_sel;
    logic [W-1:0] pat_in;
    logic [3:0]   rep;
    logic         dout, dout_valid, busy, done;

    int           n_vec  = 0;
    int           n_miss = 0;
    int           n_valid, n_done, n_busy;
    logic         model_idle;
    logic [3:0]   exp_q[$];

    seq_tx #(.WIDTH(W), .PATTERN(PAT), .GAP_LEN(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_sel   (pat_sel),
        .pat_in    (pat_in),
        .rep       (rep),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected cycle records for one whole transmission, starting with the cycle after acceptance.
    task automatic push_tx(input logic [W-1:0] p, input int reps);
        for (int r = 0; r <= reps; r++) begin
            for (int k = 0; k < W; k++) exp_q.push_back({1'b1, p[W-1-k], 1'b1, 1'b0});
            if (r < reps)
                for (int g = 0; g < G; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic clear_stats();
        n_valid = 0;
        n_done  = 0;
        n_busy  = 0;
    endtask

    // One clock: predict acceptance, advance past the edge, compare the new cycle's outputs.
    task automatic tick(input string tag);
        logic [3:0] exp;
        if (start && model_idle && !reset) push_tx(pat_sel ? pat_in : PAT, int'(rep));
        @(posedge clk);
        #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check(tag, {dout_valid, dout, busy, done}, exp);
        model_idle = (exp == 4'b0000);
        if (dout_valid) n_valid++;
        if (done)       n_done++;
        if (busy)       n_busy++;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick(tag);
        check({tag, "_drain"}, exp_q.size(), 0);
        tick(tag);
        tick(tag);
    endtask

    task automatic start_pulse(input string tag);
        start = 1'b1;
        tick(tag);
        start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pat_sel    = 1'b0;
        pat_in     = '0;
        rep        = 4'd0;
        model_idle = 1'b1;
        clear_stats();

        // Reset state, including start ignored while reset is held
        tick("reset");
        start = 1'b1;
        tick("reset_start");
        start = 1'b0;
        reset = 1'b0;
        tick("idle");

        // Single shot of the default pattern
        clear_stats();
        start_pulse("single");
        drain("single", 40);
        check("single_bits", n_valid, W);
        check("single_done", n_done, 1);

        // Run-time pattern, inputs disturbed mid-burst
        clear_stats();
        pat_sel = 1'b1;
        pat_in  = 5'b10100;
        rep     = 4'd2;
        start_pulse("runtime");
        pat_in  = 5'b01111;
        pat_sel = 1'b0;
        rep     = 4'd7;
        tick("runtime");
        drain("runtime", 60);
        check("runtime_bits", n_valid, 3 * W);
        check("runtime_done", n_done, 1);
        check("runtime_busy", n_busy, 3 * W + 2 * G);

        // Start pulse at bit 2 of a single shot is ignored
        clear_stats();
        rep = 4'd0;
        start_pulse("busy_start");
        tick("busy_start");
        tick("busy_start");
        start_pulse("busy_start");
        drain("busy_start", 40);
        check("busy_start_bits", n_valid, W);
        check("busy_start_done", n_done, 1);

        // Reset asserted at bit 3 of rep=3, then a clean restart
        rep = 4'd3;
        start_pulse("midrst");
        repeat (3) tick("midrst");
        check("midrst_bit3", {dout_valid, dout, busy}, {1'b1, PAT[W-4], 1'b1});
        reset = 1'b1;
        #1;
        check("midrst_async", {dout_valid, dout, busy, done}, 4'b0000);
        exp_q.delete();
        model_idle = 1'b1;
        clear_stats();
        tick("midrst_hold");
        reset = 1'b0;
        tick("midrst_rel");
        tick("midrst_rel");
        check("midrst_nodone", n_done, 0);
        clear_stats();
        start_pulse("restart");
        drain("restart", 120);
        check("restart_bits", n_valid, 4 * W);
        check("restart_done", n_done, 1);

        // Maximum repetitions with a random run-time pattern
        clear_stats();
        pat_sel = 1'b1;
        pat_in  = W'($urandom);
        rep     = 4'd15;
        start_pulse("maxrep");
        drain("maxrep", 200);
        check("maxrep_bits", n_valid, 16 * W);
        check("maxrep_done", n_done, 1);
        check("maxrep_busy", n_busy, 16 * W + 15 * G);

        // Start held high: back-to-back transmissions separated by one idle cycle
        clear_stats();
        pat_sel = 1'b0;
        rep     = 4'd0;
        start   = 1'b1;
        repeat (2 * (W + 2) - 1) tick("held");
        start = 1'b0;
        drain("held", 40);
        check("held_done", n_done, 2);
        check("held_bits", n_valid, 2 * W);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
